// File: rtl/attn_out_streamer_if.sv
// Capture and beat-stream signals of attn_out_streamer.
// master: the streamer itself; slave: the upstream producer plus downstream consumer.
interface attn_out_streamer_if #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned DIM     = 16,
  parameter int unsigned D_K     = 128,
  parameter int unsigned BEAT_EL = 16
);
  logic                                 I_DATA_VLD;
  logic [DIM-1:0][D_K-1:0][D_W-1:0]     I_ATT_DATA;
  logic                                 O_VLD;
  logic                                 I_RDY;
  logic [BEAT_EL*D_W-1:0]               O_BEAT;
  logic [$clog2(DIM)-1:0]               O_ROW_IDX;
  logic [$clog2(D_K/BEAT_EL)-1:0]       O_BEAT_IDX;
  logic                                 O_LAST;
  logic                                 O_BUSY;
  logic                                 O_DONE;
  logic                                 O_DROP;

  modport master (
    input  I_DATA_VLD, I_ATT_DATA, I_RDY,
    output O_VLD, O_BEAT, O_ROW_IDX, O_BEAT_IDX, O_LAST, O_BUSY, O_DONE, O_DROP
  );

  modport slave (
    output I_DATA_VLD, I_ATT_DATA, I_RDY,
    input  O_VLD, O_BEAT, O_ROW_IDX, O_BEAT_IDX, O_LAST, O_BUSY, O_DONE, O_DROP
  );
endinterface

// File: rtl/attn_out_streamer.sv
// Captures a whole DIM x D_K attention matrix in one cycle and streams it as row-major beats.
// Define ATTN_OUT_STREAMER_DBUF_EN for ping-pong buffering (one pending matrix while streaming).
module attn_out_streamer #(
  parameter int unsigned D_W     = 8,
  parameter int unsigned DIM     = 16,
  parameter int unsigned D_K     = 128,
  parameter int unsigned BEAT_EL = 16
) (
  input logic                 I_CLK,
  input logic                 I_SYNC_RST,
  attn_out_streamer_if.master bus
);
  localparam int unsigned BeatsPerRow = D_K / BEAT_EL;
  localparam int unsigned RowW        = $clog2(DIM);
  localparam int unsigned BeatW       = $clog2(BeatsPerRow);
  localparam int unsigned RowBits     = D_K * D_W;
  localparam int unsigned BeatBits    = BEAT_EL * D_W;
  localparam int unsigned OffW        = $clog2(RowBits);
  localparam logic [RowW-1:0]  LastRow  = RowW'(DIM - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerRow - 1);
`ifdef ATTN_OUT_STREAMER_DBUF_EN
  localparam int unsigned NBuf = 2;
`else
  localparam int unsigned NBuf = 1;
`endif

  if (D_K % BEAT_EL != 0) begin : g_bad_cfg
    $error("attn_out_streamer: D_K must be a multiple of BEAT_EL");
  end

  typedef logic [DIM-1:0][D_K-1:0][D_W-1:0] mat_t;
  typedef enum logic {StIdle, StSend} state_e;

  state_e           st_q, st_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
`ifdef ATTN_OUT_STREAMER_DBUF_EN
  logic             sel_q, sel_d;   // buffer currently streaming
  logic             pend_q, pend_d; // the other buffer holds a waiting matrix
`endif
  logic [NBuf-1:0]  wr_en;
  logic             start;
  mat_t             buf_q [NBuf];
  mat_t             buf_d [NBuf];

  logic hs, last, last_hs;
  assign hs      = vld_q & bus.I_RDY;
  assign last    = (row_q == LastRow) && (beat_q == LastBeat);
  assign last_hs = hs & last;

  always_comb begin
    st_d   = st_q;
    row_d  = row_q;
    beat_d = beat_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    drop_d = 1'b0;
    wr_en  = '0;
    start  = 1'b0;
`ifdef ATTN_OUT_STREAMER_DBUF_EN
    sel_d  = sel_q;
    pend_d = pend_q;
`endif
    if (hs) begin
      if (last) begin
        st_d   = StIdle;
        vld_d  = 1'b0;
        done_d = 1'b1;
      end else if (beat_q == LastBeat) begin
        beat_d = '0;
        row_d  = row_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
`ifdef ATTN_OUT_STREAMER_DBUF_EN
    if (last_hs && pend_q) begin
      sel_d  = ~sel_q;
      pend_d = 1'b0;
      start  = 1'b1;
    end
    if (bus.I_DATA_VLD) begin
      if (st_q == StIdle) begin
        wr_en[sel_q] = 1'b1;
        start        = 1'b1;
      end else if (pend_q && !last_hs) begin
        drop_d = 1'b1;
      end else if (pend_q) begin
        // Pending buffer starts now, so the just-finished one takes the new matrix.
        wr_en[sel_q] = 1'b1;
        pend_d       = 1'b1;
      end else begin
        wr_en[~sel_q] = 1'b1;
        if (last_hs) begin
          sel_d = ~sel_q;
          start = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
      end
    end
`else
    if (bus.I_DATA_VLD) begin
      if (st_q == StIdle || last_hs) begin
        wr_en[0] = 1'b1;
        start    = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
`endif
    if (start) begin
      st_d   = StSend;
      vld_d  = 1'b1;
      row_d  = '0;
      beat_d = '0;
    end
    for (int i = 0; i < NBuf; i++) begin
      buf_d[i] = wr_en[i] ? bus.I_ATT_DATA : buf_q[i];
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      st_q   <= StIdle;
      row_q  <= '0;
      beat_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
`ifdef ATTN_OUT_STREAMER_DBUF_EN
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      row_q  <= row_d;
      beat_q <= beat_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      drop_q <= drop_d;
`ifdef ATTN_OUT_STREAMER_DBUF_EN
      sel_q  <= sel_d;
      pend_q <= pend_d;
`endif
    end
  end

  // Matrix storage needs no reset; occupancy is tracked by the FSM flags.
  always_ff @(posedge I_CLK) begin
    buf_q <= buf_d;
  end

  logic [RowBits-1:0] row_bits;
  logic [OffW-1:0]    off;
  always_comb begin
`ifdef ATTN_OUT_STREAMER_DBUF_EN
    row_bits = buf_q[sel_q][row_q];
`else
    row_bits = buf_q[0][row_q];
`endif
    off = OffW'(32'(beat_q) * BeatBits);
  end

  assign bus.O_VLD      = vld_q;
  assign bus.O_BEAT     = vld_q ? row_bits[off +: BeatBits] : '0;
  assign bus.O_ROW_IDX  = row_q;
  assign bus.O_BEAT_IDX = beat_q;
  assign bus.O_LAST     = vld_q & last;
  assign bus.O_BUSY     = (st_q == StSend);
  assign bus.O_DONE     = done_q;
  assign bus.O_DROP     = drop_q;
endmodule
